// File: rtl/norm_pkg.sv
// Shared types and constants for the CLZ / normalize sequencer.
package norm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;

  localparam logic OP_CLZ  = 1'b0;
  localparam logic OP_NORM = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic              op;
    logic              id;
  } req_t;

  // A count of 32 (bit 5 set) clears the word instead of wrapping the shift amount.
  function automatic logic [DATA_W-1:0] shl_sat(input logic [DATA_W-1:0] a,
                                                input logic [CNT_W-1:0]  n);
    return n[CNT_W-1] ? '0 : (a << n[CNT_W-2:0]);
  endfunction

endpackage

// File: rtl/norm_sched_clz.sv
// Combinational 32-bit count-leading-zeros; all-zero input yields 32.
module clz (
  input  logic [31:0] a_i,
  output logic [31:0] count_o
);

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    count_o = 32'd32;
    for (int unsigned i = 0; i < 32; i++) begin
      if (a_i[i]) count_o = 32'(31 - i);
    end
  end

endmodule

// File: rtl/norm_sched.sv
// Two-requester arbiter and sequencer around a shared clz and left shifter.
module norm_sched #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [31:0] res_value,
  output logic [5:0]  res_count,
  output logic        busy
);
  import norm_pkg::*;

  state_t             state_q;
  req_t               req_q;
  logic               ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  value_q;
  logic               valid_q;
  logic               busy_q;

  logic               grant0;
  logic               grant1;
  logic [31:0]        clz_raw;
  logic [CNT_W-1:0]   clz_cnt;
  logic               unused_clz_hi;

  clz u_clz (
    .a_i     (req_q.a),
    .count_o (clz_raw)
  );

  assign clz_cnt       = clz_raw[CNT_W-1:0];
  assign unused_clz_hi = ^clz_raw[31:CNT_W];

  // ptr_q names the requester that wins a tie when round-robin is enabled.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (FAIR && req0_valid && req1_valid) begin
      grant0 = ~ptr_q;
      grant1 = ptr_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) & grant0 & ~reset;
  assign req1_ready = (state_q == IDLE) & grant1 & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            req_q.a  <= req1_ready ? req1_a  : req0_a;
            req_q.op <= req1_ready ? req1_op : req0_op;
            req_q.id <= req1_ready;
            busy_q   <= 1'b1;
            state_q  <= COUNT;
          end
        end
        COUNT: begin
          cnt_q <= clz_cnt;
          if (req_q.op == OP_CLZ) begin
            value_q <= {{(DATA_W-CNT_W){1'b0}}, clz_cnt};
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          value_q <= shl_sat(req_q.a, cnt_q);
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= ~req_q.id;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = valid_q;
  assign res_id    = req_q.id;
  assign res_value = value_q;
  assign res_count = cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_norm_sched.sv
// Bench for norm_sched: round-robin and fixed-priority instances share stimulus
// and are checked every cycle against a transaction-level reference model.
module tb_norm_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1, op0, op1, res_ready;
  logic [31:0] a0, a1;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv   [2];
  logic        rid  [2];
  logic        bsy  [2];
  logic [31:0] rval [2];
  logic [5:0]  rcnt [2];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state, index 0 = FAIR instance, 1 = fixed-priority instance.
  bit          m_inf  [2];
  bit          m_rv   [2];
  bit          m_zero [2];
  bit          m_pref [2];
  bit          m_id   [2];
  int          m_age  [2];
  int          m_lat  [2];
  logic [5:0]  m_cnt  [2];
  logic [31:0] m_val  [2];

  int hist0[$];
  int hist1[$];

  norm_sched #(.FAIR(1'b1)) u_fair (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(rdy0[0]), .req0_op(op0), .req0_a(a0),
    .req1_valid(v1), .req1_ready(rdy1[0]), .req1_op(op1), .req1_a(a1),
    .res_valid(rv[0]), .res_ready(res_ready), .res_id(rid[0]),
    .res_value(rval[0]), .res_count(rcnt[0]), .busy(bsy[0])
  );

  norm_sched #(.FAIR(1'b0)) u_prio (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(rdy0[1]), .req0_op(op0), .req0_a(a0),
    .req1_valid(v1), .req1_ready(rdy1[1]), .req1_op(op1), .req1_a(a1),
    .res_valid(rv[1]), .res_ready(res_ready), .res_id(rid[1]),
    .res_value(rval[1]), .res_count(rcnt[1]), .busy(bsy[1])
  );

  initial forever #5 clk = ~clk;

  function automatic int clzf(input logic [31:0] a);
    for (int i = 31; i >= 0; i--) if (a[i]) return 31 - i;
    return 32;
  endfunction

  // Returns {grant1, grant0}; only instance 0 honours the preference on a tie.
  function automatic logic [1:0] grantf(input int k, input bit pref, input logic va, input logic vb);
    if (va && vb) return (k == 0 && pref) ? 2'b10 : 2'b01;
    return {vb & ~va, va};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Model update on every rising edge from the inputs present before the edge.
  initial begin
    logic [1:0]  g;
    logic        sel;
    logic [31:0] aa;
    logic        oo;
    int          c;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          m_inf[k] = 0; m_rv[k] = 0; m_zero[k] = 1; m_pref[k] = 0;
        end else if (!m_inf[k]) begin
          g = grantf(k, m_pref[k], v0, v1);
          if (g != 2'b00) begin
            sel = g[1];
            aa  = sel ? a1 : a0;
            oo  = sel ? op1 : op0;
            c   = clzf(aa);
            m_inf[k]  = 1;
            m_age[k]  = 0;
            m_id[k]   = sel;
            m_cnt[k]  = 6'(c);
            m_val[k]  = oo ? ((c >= 32) ? 32'd0 : (aa << c)) : 32'(c);
            m_lat[k]  = oo ? 3 : 2;
            m_zero[k] = 0;
          end
        end else if (m_rv[k]) begin
          if (res_ready) begin
            m_inf[k]  = 0;
            m_rv[k]   = 0;
            m_pref[k] = !m_id[k];
          end
        end else begin
          m_age[k]++;
          if (m_age[k] == m_lat[k] - 1) m_rv[k] = 1;
        end
      end
      if (reset) chk_en = 1'b1;
    end
  end

  // Single compare process: every falling edge, both instances against the model.
  initial begin
    logic [1:0] g;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          g = grantf(k, m_pref[k], v0, v1);
          chk($sformatf("d%0d.req0_ready", k), 32'(rdy0[k]), 32'(!reset && !m_inf[k] && g[0]));
          chk($sformatf("d%0d.req1_ready", k), 32'(rdy1[k]), 32'(!reset && !m_inf[k] && g[1]));
          chk($sformatf("d%0d.busy", k), 32'(bsy[k]), 32'(m_inf[k]));
          chk($sformatf("d%0d.res_valid", k), 32'(rv[k]), 32'(m_rv[k]));
          if (m_rv[k] || m_zero[k]) begin
            chk($sformatf("d%0d.res_id", k), 32'(rid[k]), m_zero[k] ? 32'd0 : 32'(m_id[k]));
            chk($sformatf("d%0d.res_count", k), 32'(rcnt[k]), m_zero[k] ? 32'd0 : 32'(m_cnt[k]));
            chk($sformatf("d%0d.res_value", k), rval[k], m_zero[k] ? 32'd0 : m_val[k]);
          end
          if (rv[k] && res_ready && !reset) begin
            if (k == 0) hist0.push_back(int'(rid[k]));
            else        hist1.push_back(int'(rid[k]));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'h8000_0000 | $urandom;
      2:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; v0 = 0; v1 = 0; res_ready = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic drain(input string nm);
    bit ok = 0;
    v0 = 0; v1 = 0; res_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bsy[0] && !bsy[1]) begin ok = 1; break; end
    end
    if (!ok) timeout(nm);
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  task automatic wait_accept(input int rq, input string nm, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((rq == 0) ? rdy0[0] : rdy1[0]) begin ok = 1; break; end
    end
    if (!ok) timeout(nm);
  endtask

  // One isolated request; both instances see the same single-valid traffic.
  task automatic run_one(input string nm, input int rq, input logic op, input logic [31:0] a,
                         input int elat, input int ecnt, input logic [31:0] eval);
    bit ok;
    int lat;
    @(posedge clk); #1;
    v0 = (rq == 0); v1 = (rq == 1); op0 = op; op1 = op; a0 = a; a1 = a; res_ready = 0;
    wait_accept(rq, {nm, ".accept"}, ok);
    if (!ok) begin drain(nm); return; end
    @(posedge clk); #1;
    v0 = 0; v1 = 0; a0 = $urandom; a1 = $urandom; op0 = ~op; op1 = ~op;
    lat = 0; ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (rv[0]) begin ok = 1; break; end
    end
    if (!ok) timeout({nm, ".result"});
    else begin
      chk({nm, ".latency"}, 32'(lat), 32'(elat));
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("%s.d%0d.valid", nm, k), 32'(rv[k]), 32'd1);
        chk($sformatf("%s.d%0d.count", nm, k), 32'(rcnt[k]), 32'(ecnt));
        chk($sformatf("%s.d%0d.value", nm, k), rval[k], eval);
        chk($sformatf("%s.d%0d.id", nm, k), 32'(rid[k]), 32'(rq));
      end
    end
    @(posedge clk); #1;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  initial begin
    bit ok;
    reset = 1; v0 = 0; v1 = 0; op0 = 0; op1 = 0; a0 = '0; a1 = '0; res_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    run_one("clz_basic",  0, 1'b0, 32'h0001_0000, 2, 15, 32'h0000_000F);
    run_one("norm_basic", 1, 1'b1, 32'h0000_0003, 3, 30, 32'hC000_0000);
    run_one("clz_zero",   0, 1'b0, 32'h0000_0000, 2, 32, 32'h0000_0020);
    run_one("norm_zero",  1, 1'b1, 32'h0000_0000, 3, 32, 32'h0000_0000);
    run_one("norm_msb",   0, 1'b1, 32'h8000_0000, 3, 0,  32'h8000_0000);

    // Result held in DONE while the consumer stalls.
    @(posedge clk); #1;
    v1 = 1; op1 = 0; a1 = 32'h0000_0100;
    wait_accept(1, "hold.accept", ok);
    @(posedge clk); #1;
    v1 = 0;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv[0]) begin ok = 1; break; end
    end
    if (!ok) timeout("hold.result");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      v0 = 1; v1 = 1; op0 = 0; op1 = 0; a0 = $urandom; a1 = $urandom; res_ready = 0;
      @(negedge clk);
      chk("hold.valid", 32'(rv[0]), 32'd1);
      chk("hold.count", 32'(rcnt[0]), 32'd23);
      chk("hold.value", rval[0], 32'd23);
      chk("hold.id", 32'(rid[0]), 32'd1);
      chk("hold.ready0", 32'(rdy0[0]), 32'd0);
      chk("hold.ready1", 32'(rdy1[0]), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    @(negedge clk);
    chk("hold.next_ready0", 32'(rdy0[0]), 32'd1);
    @(posedge clk); #1;
    drain("hold.drain");

    // Both requesters saturating: alternation vs. fixed priority.
    do_reset();
    hist0.delete();
    hist1.delete();
    v0 = 1; v1 = 1; op0 = 0; op1 = 0; a0 = $urandom; a1 = $urandom; res_ready = 1;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (hist0.size() >= 4 && hist1.size() >= 4) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    drain("arb.drain");
    if (!ok) timeout("arb.grants");
    else begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("arb.fair[%0d]", i), 32'(hist0[i]), 32'(i % 2));
        chk($sformatf("arb.prio[%0d]", i), 32'(hist1[i]), 32'd0);
      end
    end

    // Reset while a NORM is in SHIFT, after requester 0 was served last.
    run_one("pre_rst", 0, 1'b0, 32'h0000_1234, 2, 19, 32'd19);
    @(posedge clk); #1;
    v0 = 1; op0 = 1; a0 = 32'h0000_0005;
    wait_accept(0, "rst.accept", ok);
    @(posedge clk); #1;
    v0 = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    hist0.delete();
    hist1.delete();
    v0 = 1; v1 = 1; op0 = 0; op1 = 0; res_ready = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst.d%0d.valid", k), 32'(rv[k]), 32'd0);
      chk($sformatf("rst.d%0d.busy", k), 32'(bsy[k]), 32'd0);
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hist0.size() >= 1 && hist1.size() >= 1) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    drain("rst.drain");
    if (!ok) timeout("rst.first_grant");
    else begin
      chk("rst.fair_first", 32'(hist0[0]), 32'd0);
      chk("rst.prio_first", 32'(hist1[0]), 32'd0);
    end

    // Randomized traffic, checked cycle by cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 199) == 0);
      v0        = ($urandom_range(0, 9) < 6);
      v1        = ($urandom_range(0, 9) < 6);
      op0       = 1'($urandom_range(0, 1));
      op1       = 1'($urandom_range(0, 1));
      a0        = rnd_operand();
      a1        = rnd_operand();
      res_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    reset = 0;
    drain("final.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/norm_sched.md
# norm_sched

Sequencer and arbiter for the shared 32-bit count-leading-zeros datapath. Two requesters submit CLZ or NORMALIZE operations: the fetch/decode ALU path and the float-normalize path. The block grants one request at a time, then runs it through a single `clz` instance and a single left barrel shifter. Results are returned over a valid/ready handshake tagged with the requester id.

## Interface
- `FAIR`, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0 request accepted this cycle.
- `req0_op` in 1: 0 = CLZ, 1 = NORM.
- `req0_a` in 32: operand.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`: same as requester 0, for requester 1.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes the result.
- `res_id` out 1: requester the result belongs to.
- `res_value` out 32: CLZ gives the count zero-extended; NORM gives the operand shifted left by the count.
- `res_count` out 6: leading-zero count, 0..32.
- `busy` out 1: state is not IDLE.

## Operation
- States and transitions:
  - **IDLE**: arbitrate. A request is accepted when its valid and ready are both high; ready is high only for the granted requester.
    - On accept, latch `a`, `op` and `id`, then go to COUNT.
  - **COUNT**: drive the latched operand into `clz`; register the 6-bit count.
    - op = CLZ: set `value = {26'b0, count}` and go to DONE.
    - op = NORM: go to SHIFT.
  - **SHIFT**: `value = operand << count`, computed on 32 bits; go to DONE.
  - **DONE**: `res_valid = 1`. When `res_ready` is high, go to IDLE and update the round-robin pointer.
- Arbitration:
  - `req*_ready = (state == IDLE) & grant*`; the grant is combinational from the valids and the pointer.
  - With `FAIR = 1`, the requester not served last wins a tie.
  - With `FAIR = 0`, requester 0 wins every tie.
  - Only one transaction is ever in flight.
- Zero operand: count = 32.
  - CLZ returns value 32.
  - NORM returns value 0; the shift by 32 must yield 0, not wrap.
- Operand with MSB set: count = 0; NORM returns the operand unchanged.
- The latched operand, op and id are stable from accept until the DONE handshake. Changes on `req*_a` after accept have no effect.
- Reset values:
  - state = IDLE; pointer prefers requester 0.
  - `res_valid = 0`, `res_id = 0`, `res_value = 0`, `res_count = 0`, `busy = 0`.
  - Both `req*_ready = 0` during the reset cycle.
- Reset mid-operation: the transaction is dropped with no result. The next accept follows the reset pointer (requester 0 first).

## Timing
- Accept in cycle t (valid & ready at edge t):
  - CLZ: `res_valid` high from t+2.
  - NORM: `res_valid` high from t+3.
- DONE holds `res_*` stable while `res_ready` is low, for any number of cycles.
- The handshake at edge d returns the block to IDLE. The next accept is possible at edge d+1.
- Minimum issue interval: 3 cycles for CLZ, 4 for NORM.
- `res_valid` and all `res_*` are registered; the only combinational outputs are `req*_ready`.
- A `res_ready` that is high in IDLE, COUNT or SHIFT is ignored.

## Structure
- Shared package `norm_pkg`:
  - op encodings `OP_CLZ = 1'b0`, `OP_NORM = 1'b1`.
  - 2-bit state enum: IDLE, COUNT, SHIFT, DONE.
  - `CNT_W = 6`.
- Sub-module: one instance of the existing combinational `clz`. Its low 6 output bits are used; the upper 26 bits are ignored.
- The arbiter stays inline; it is small.

## Test plan
- req0 CLZ, a = 0x00010000 → at t+2: `res_count = 15`, `res_value = 0x0000000F`, `res_id = 0`.
- req1 NORM, a = 0x00000003 → at t+3: `res_count = 30`, `res_value = 0xC0000000`, `res_id = 1`.
- a = 0 with CLZ, then a = 0 with NORM → count 32 with value 0x20, then count 32 with value 0. a = 0x80000000 NORM → count 0, value 0x80000000.
- Both valid continuously, `res_ready = 1`:
  - `FAIR = 1` → grants alternate 0,1,0,1.
  - `FAIR = 0` → all grants go to 0 while `req0_valid` stays high.
- `res_ready` held low 5 cycles in DONE → `res_*` constant, both `req*_ready = 0`. The request is accepted the cycle after the handshake.
- `reset` asserted during SHIFT → the next cycle shows `res_valid = 0` and `busy = 0`. No result for the dropped operation. With both valid, the first post-reset grant goes to requester 0.
